// File: rtl/parc_mem_arb_pkg.sv
// rtl/parc_mem_arb_pkg.sv - shared source IDs and default message widths for the PARCv2 memory arbiter
package parc_mem_arb_pkg;

  // Widths follow the vc memory message layout: {type, addr, len, data} / {type, len, data}
  function automatic int vc_mem_req_msg_sz(input int addr_sz, input int data_sz);
    return 1 + addr_sz + $clog2(data_sz / 8) + data_sz;
  endfunction

  function automatic int vc_mem_resp_msg_sz(input int data_sz);
    return 1 + $clog2(data_sz / 8) + data_sz;
  endfunction

  localparam int PARC_MEM_ARB_REQ_SZ  = vc_mem_req_msg_sz(32, 32);
  localparam int PARC_MEM_ARB_RESP_SZ = vc_mem_resp_msg_sz(32);

  localparam logic PARC_MEM_ARB_SRC_IMEM = 1'b0;
  localparam logic PARC_MEM_ARB_SRC_DMEM = 1'b1;

endpackage

// File: rtl/parc_mem_arb_tag_queue.sv
// rtl/parc_mem_arb_tag_queue.sv - circular 1-bit FIFO of request source IDs, popped in response order
module parc_MemArbTagQueue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     push_src,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     head
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0] r_slots;
  logic [AW-1:0]    r_head;
  logic [AW-1:0]    r_tail;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  // A push into a full queue is legal only when a pop frees the head slot in the same cycle
  assign w_push = push & (~full | pop);
  assign w_pop  = pop & ~empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_slots <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_slots[r_tail] <= push_src;
        r_tail          <= r_tail + 1'b1;
      end
      if (w_pop) begin
        r_head <= r_head + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign full  = (r_count == (AW + 1)'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;
  assign head  = r_slots[r_head];

endmodule

// File: rtl/parc_mem_arb.sv
// rtl/parc_mem_arb.sv - imem/dmem to single memory port arbiter; PARC_MEM_ARB_ROUND_ROBIN_EN selects round-robin ties
module parc_mem_arb
  import parc_mem_arb_pkg::*;
#(
  parameter int REQ_SZ          = PARC_MEM_ARB_REQ_SZ,
  parameter int RESP_SZ         = PARC_MEM_ARB_RESP_SZ,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [REQ_SZ-1:0]  imemreq_msg,
  input  logic               imemreq_val,
  output logic               imemreq_rdy,
  input  logic [REQ_SZ-1:0]  dmemreq_msg,
  input  logic               dmemreq_val,
  output logic               dmemreq_rdy,
  output logic [RESP_SZ-1:0] imemresp_msg,
  output logic               imemresp_val,
  output logic [RESP_SZ-1:0] dmemresp_msg,
  output logic               dmemresp_val,
  output logic [REQ_SZ-1:0]  memreq_msg,
  output logic               memreq_val,
  input  logic               memreq_rdy,
  input  logic [RESP_SZ-1:0] memresp_msg,
  input  logic               memresp_val,
  output logic               err
);

  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

  logic          w_full;
  logic          w_empty;
  logic          w_head;
  logic [CW-1:0] w_count;
  logic          w_resp_ok;
  logic          w_issue_ok;
  logic          w_tie_src;
  logic          w_grant_src;
  logic          w_any_req;
  logic          w_fire;
  logic          r_err;

  // A response only counts when something is outstanding; otherwise it is dropped and flagged
  assign w_resp_ok  = reset & memresp_val & ~w_empty;
  assign w_issue_ok = ~w_full | w_resp_ok;

`ifdef PARC_MEM_ARB_ROUND_ROBIN_EN
  logic r_last_grant;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_grant <= PARC_MEM_ARB_SRC_DMEM;
    end else if (w_fire) begin
      r_last_grant <= w_grant_src;
    end
  end

  assign w_tie_src = ~r_last_grant;
`else
  assign w_tie_src = PARC_MEM_ARB_SRC_DMEM;
`endif

  assign w_grant_src = (imemreq_val & dmemreq_val) ? w_tie_src : dmemreq_val;
  assign w_any_req   = reset & (imemreq_val | dmemreq_val);

  assign memreq_val  = w_any_req & w_issue_ok;
  assign memreq_msg  = (w_grant_src == PARC_MEM_ARB_SRC_DMEM) ? dmemreq_msg : imemreq_msg;
  assign w_fire      = memreq_val & memreq_rdy;

  assign imemreq_rdy = reset & imemreq_val & (w_grant_src == PARC_MEM_ARB_SRC_IMEM)
                       & memreq_rdy & w_issue_ok;
  assign dmemreq_rdy = reset & dmemreq_val & (w_grant_src == PARC_MEM_ARB_SRC_DMEM)
                       & memreq_rdy & w_issue_ok;

  parc_MemArbTagQueue #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_queue (
    .clk      (clk),
    .reset    (reset),
    .push     (w_fire),
    .push_src (w_grant_src),
    .pop      (w_resp_ok),
    .full     (w_full),
    .empty    (w_empty),
    .count    (w_count),
    .head     (w_head)
  );

  assign imemresp_val = w_resp_ok & (w_head == PARC_MEM_ARB_SRC_IMEM);
  assign dmemresp_val = w_resp_ok & (w_head == PARC_MEM_ARB_SRC_DMEM);
  assign imemresp_msg = memresp_msg;
  assign dmemresp_msg = memresp_msg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err <= 1'b0;
    end else if (memresp_val & w_empty) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;

  logic w_unused;
  assign w_unused = ^w_count;

endmodule
